// File: rtl/subleq_pkg.sv
// -----------------------------------------------------------------------------
// subleq_pkg
// Shared definitions for the SUBLEQ engine:
//   state_t     - sequencing states of the engine
//   word_bytes  - number of bytes in one data word
// -----------------------------------------------------------------------------
package subleq_pkg;

   typedef enum logic [2:0] {
      ST_FETCH_A = 3'd0,
      ST_FETCH_B = 3'd1,
      ST_FETCH_C = 3'd2,
      ST_READ_A  = 3'd3,
      ST_READ_B  = 3'd4,
      ST_WRITE   = 3'd5,
      ST_HALT    = 3'd6
   } state_t;

   function automatic int word_bytes(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/subleq_byteswap.sv
// -----------------------------------------------------------------------------
// subleq_byteswap
// Reverses the byte order of a data word, or passes it through unchanged.
// Parameters: DATA_W (word width, multiple of 8), BYTE_SWAP (1 = reverse).
// Ports:
//   din   in   DATA_W  word to convert
//   dout  out  DATA_W  converted word
// -----------------------------------------------------------------------------
module subleq_byteswap
   import subleq_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int BYTE_SWAP = 1
) (
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   localparam int NB = word_bytes(DATA_W);

   generate
      if (BYTE_SWAP != 0) begin : g_swap
         for (genvar i = 0; i < NB; i++) begin : g_byte
            assign dout[8*i +: 8] = din[8*(NB-1-i) +: 8];
         end
      end else begin : g_pass
         assign dout = din;
      end
   endgenerate

endmodule

// File: rtl/subleq_engine.sv
// -----------------------------------------------------------------------------
// subleq_engine
// Single-instruction (SUBLEQ A,B,C) processor driving one request/acknowledge
// memory port. Each instruction is six accesses: fetch A, B, C, read mem[A],
// read mem[B], write mem[B]-mem[A] back to B; then branch to C if the result
// is <= 0 (signed), else fall through by three words.
// Optional build macro: SUBLEQ_HALT_EN - a taken branch to its own pc stops
// the core (halted=1) until reset; without it halted is tied to 0.
// Ports:
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous active-low reset
//   cpu_en     in   1       allow new requests; 0 stalls at a request boundary
//   mem_req    out  1       request valid
//   mem_we     out  1       1 = write, 0 = read
//   mem_addr   out  ADDR_W  byte address
//   mem_wdata  out  DATA_W  write data (byte order per BYTE_SWAP)
//   mem_ack    in   1       request accepted / read data valid
//   mem_rdata  in   DATA_W  read data (byte order per BYTE_SWAP)
//   halted     out  1       core stopped
//   retired    out  32      completed instruction count (wraps)
// -----------------------------------------------------------------------------
module subleq_engine
   import subleq_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int          ADDR_W    = 32,
   parameter int          BYTE_SWAP = 1,
   parameter int unsigned RESET_PC  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_en,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              halted,
   output logic [31:0]       retired
);

   localparam int              WB         = word_bytes(DATA_W);
   localparam logic [ADDR_W-1:0] STEP1    = ADDR_W'(WB);
   localparam logic [ADDR_W-1:0] STEP2    = ADDR_W'(2 * WB);
   localparam logic [ADDR_W-1:0] STEP3    = ADDR_W'(3 * WB);
   localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
   logic [DATA_W-1:0]   opa_q, opa_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic [31:0]         retired_q, retired_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   wr_word;
   logic [ADDR_W-1:0]   nxt_addr;
   logic                fire;
   logic                taken;

   subleq_byteswap #(.DATA_W(DATA_W), .BYTE_SWAP(BYTE_SWAP)) u_rd_swap (
      .din  (mem_rdata),
      .dout (rd_word)
   );

   subleq_byteswap #(.DATA_W(DATA_W), .BYTE_SWAP(BYTE_SWAP)) u_wr_swap (
      .din  (res_d),
      .dout (wr_word)
   );

   assign fire  = mem_req_q & mem_ack;
   // Signed "<= 0" on the wrapped difference: sign bit set or all zero.
   assign taken = res_q[DATA_W-1] | ~|res_q;

   // Instruction datapath: advances only on an acknowledged request.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_d   = state_q;
      pc_d      = pc_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      opa_d     = opa_q;
      res_d     = res_q;
      retired_d = retired_q;
      if (fire) begin
         case (state_q)
            ST_FETCH_A: begin a_d = rd_word[ADDR_W-1:0]; state_d = ST_FETCH_B; end
            ST_FETCH_B: begin b_d = rd_word[ADDR_W-1:0]; state_d = ST_FETCH_C; end
            ST_FETCH_C: begin c_d = rd_word[ADDR_W-1:0]; state_d = ST_READ_A;  end
            ST_READ_A:  begin opa_d = rd_word;           state_d = ST_READ_B;  end
            ST_READ_B:  begin res_d = rd_word - opa_q;   state_d = ST_WRITE;   end
            ST_WRITE: begin
               retired_d = retired_q + 32'd1;
               state_d   = ST_FETCH_A;
               if (taken) begin
                  pc_d = c_q;
`ifdef SUBLEQ_HALT_EN
                  if (c_q == pc_q) state_d = ST_HALT;
`endif
               end else begin
                  pc_d = pc_q + STEP3;
               end
            end
            default: ;
         endcase
      end
   end

   // Bus side: a new request is launched when the previous one is accepted
   // (or none is pending) and cpu_en allows it; a pending request is never
   // withdrawn or altered before its acknowledge.
   always_comb begin
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_d)
         ST_FETCH_A: nxt_addr = pc_d;
         ST_FETCH_B: nxt_addr = pc_d + STEP1;
         ST_FETCH_C: nxt_addr = pc_d + STEP2;
         ST_READ_A:  nxt_addr = a_d;
         default:    nxt_addr = b_d;
      endcase
      if (state_d != ST_HALT && cpu_en && (fire || !mem_req_q)) begin
         mem_req_d   = 1'b1;
         mem_we_d    = (state_d == ST_WRITE);
         mem_addr_d  = nxt_addr;
         mem_wdata_d = wr_word;
      end else if (fire) begin
         mem_req_d = 1'b0;
         mem_we_d  = 1'b0;
      end
   end

   // NOTE: async active-low reset clears all state; non-blocking assignments
   // keep every flop sampling pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_FETCH_A;
         pc_q        <= RESET_PC_A;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         opa_q       <= '0;
         res_q       <= '0;
         retired_q   <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         opa_q       <= opa_d;
         res_q       <= res_d;
         retired_q   <= retired_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign retired   = retired_q;
`ifdef SUBLEQ_HALT_EN
   assign halted    = (state_q == ST_HALT);
`else
   assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_subleq_engine.sv
`timescale 1ns/1ps
module tb_subleq_engine;

   // ---------------- main DUT (defaults) ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_en = 1'b0;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        halted;
   logic [31:0] retired;

   always #5 clk = ~clk;

   subleq_engine dut (
      .clk(clk), .rst(rst), .cpu_en(cpu_en),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .halted(halted), .retired(retired)
   );

   // ---------------- narrow DUT: 16-bit data, 8-bit address ----------------
   logic        s_en = 1'b0;
   logic        s_ack;
   logic        s_req, s_we, s_halted;
   logic [7:0]  s_addr;
   logic [15:0] s_wdata, s_rdata;
   logic [31:0] s_retired;
   logic [15:0] smem [128];

   subleq_engine #(.DATA_W(16), .ADDR_W(8), .BYTE_SWAP(0), .RESET_PC(252)) dut_s (
      .clk(clk), .rst(rst), .cpu_en(s_en),
      .mem_req(s_req), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
      .mem_ack(s_ack), .mem_rdata(s_rdata),
      .halted(s_halted), .retired(s_retired)
   );

   assign s_rdata = smem[s_addr[7:1]];
   always @(posedge clk) if (rst && s_req && s_we) smem[s_addr[7:1]] <= s_wdata;

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // Memory holds words exactly as they appear on the bus (byte-swapped).
   logic [31:0] mem [256];
   logic [31:0] lm [256];
   logic [31:0] exp_mem [256];
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];

   // ---------------- memory responder ----------------
   int          max_delay = 0;
   int          wait_cnt = 0;
   bit          pend = 0;
   int          fire_cnt = 0;
   bit          sb_on = 0;
   int          sb_writes = 0;
   logic [31:0] hold_addr, hold_wdata;
   logic        hold_we;

   initial begin
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst || !mem_req) begin
            mem_ack = 1'b0;
            pend = 0;
            mem_rdata = $urandom;
         end else begin
            if (pend) begin
               check("hold_addr", mem_addr, hold_addr);
               check("hold_we", mem_we, hold_we);
               check("hold_wdata", mem_wdata, hold_wdata);
            end else begin
               wait_cnt = int'($urandom_range(max_delay, 0));
               hold_addr = mem_addr;
               hold_we = mem_we;
               hold_wdata = mem_wdata;
            end
            if (wait_cnt == 0) begin
               mem_ack = 1'b1;
               pend = 0;
               fire_cnt++;
               mem_rdata = mem[mem_addr[9:2]];
               if (mem_we) begin
                  mem[mem_addr[9:2]] = mem_wdata;
                  if (sb_on && exp_addr_q.size() != 0) begin
                     check("sb_write_addr", mem_addr, exp_addr_q.pop_front());
                     check("sb_write_data", bswap(mem_wdata), exp_data_q.pop_front());
                     sb_writes++;
                  end
               end
            end else begin
               mem_ack = 1'b0;
               mem_rdata = $urandom;
               wait_cnt--;
               pend = 1;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      cpu_en = 1'b1;
      rst = 1'b0;
      repeat (3) tick();
      check("rst_req", mem_req, 1'b0);
      check("rst_we", mem_we, 1'b0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_retired", retired, 32'h0);
      check("rst_halted", halted, 1'b0);
      cpu_en = 1'b0;
      rst = 1'b1;
      tick();
   endtask

   task automatic wait_retired(input logic [31:0] target, input int budget, output int cycles);
      cycles = 0;
      while (retired !== target && cycles < budget) begin
         tick();
         cycles++;
      end
      if (retired !== target) check("timeout_retired", retired, target);
   endtask

   task automatic load_prog(input logic [31:0] a, b, c, va, vb);
      foreach (mem[i]) mem[i] = '0;
      mem[0] = bswap(a);
      mem[1] = bswap(b);
      mem[2] = bswap(c);
      if (a != b) mem[a[9:2]] = bswap(va);
      mem[b[9:2]] = bswap(vb);
   endtask

   function automatic logic [31:0] rd(input logic [31:0] addr);
      return lm[addr[9:2]];
   endfunction

   task automatic run_basic(input string tag, input logic [31:0] va, vb, exp_b, exp_pc, input int delay);
      int cyc;
      max_delay = delay;
      load_prog(32'd16, 32'd20, 32'd0, va, vb);
      do_reset();
      cpu_en = 1'b1;
      wait_retired(32'd1, 200, cyc);
      cpu_en = 1'b0;
      check({tag, "_next_pc"}, mem_addr, exp_pc);
      repeat (8) tick();
      check({tag, "_mem20"}, bswap(mem[5]), exp_b);
      check({tag, "_retired_hold"}, retired, 32'd1);
   endtask

   // ---------------- directed + random sequence ----------------
   localparam int N_RAND = 40;

   initial begin
      int n;
      int viol;
      int mism;
      logic [31:0] pc, a, b, c, r;
      s_ack = 1'b1;

      // Reset values, idle hold, first request and 6-cycle instruction.
      max_delay = 0;
      load_prog(32'd16, 32'd20, 32'd0, 32'd5, 32'd3);
      do_reset();
      tick();
      check("idle_no_req", mem_req, 1'b0);
      cpu_en = 1'b1;
      tick();
      check("first_req", mem_req, 1'b1);
      check("first_addr", mem_addr, 32'h0);
      check("first_we", mem_we, 1'b0);
      n = 0;
      while (retired !== 32'd1 && n < 50) begin
         tick();
         n++;
      end
      check("cycles_per_instr", n, 6);
      cpu_en = 1'b0;
      check("basic_next_pc", mem_addr, 32'h0);
      repeat (4) tick();
      check("basic_mem20", bswap(mem[5]), 32'hFFFF_FFFE);

      // Not-taken branch.
      run_basic("nt", 32'd3, 32'd5, 32'd2, 32'd12, 0);
      // Random acknowledge latency.
      run_basic("delay", 32'd5, 32'd3, 32'hFFFF_FFFE, 32'd0, 5);

      // cpu_en dropped while READ_B is in flight.
      max_delay = 3;
      load_prog(32'd16, 32'd20, 32'd0, 32'd5, 32'd3);
      do_reset();
      fire_cnt = 0;
      cpu_en = 1'b1;
      n = 0;
      while (fire_cnt < 5 && n < 200) begin
         tick();
         n++;
      end
      check("stall_reach_read_b", fire_cnt, 5);
      check("stall_read_b_addr", mem_addr, 32'd20);
      cpu_en = 1'b0;
      viol = 0;
      repeat (10) begin
         tick();
         if (mem_req !== 1'b0) viol++;
      end
      check("stall_req_low", viol, 0);
      check("stall_no_retire", retired, 32'd0);
      cpu_en = 1'b1;
      wait_retired(32'd1, 200, n);
      check("stall_next_pc", mem_addr, 32'd0);
      cpu_en = 1'b0;
      repeat (6) tick();
      check("stall_mem20", bswap(mem[5]), 32'hFFFF_FFFE);

      // Self-loop: SUBLEQ 16,16,0 at address 0.
      max_delay = 1;
      load_prog(32'd16, 32'd16, 32'd0, 32'd7, 32'd7);
      do_reset();
      cpu_en = 1'b1;
`ifdef SUBLEQ_HALT_EN
      wait_retired(32'd1, 200, n);
      check("halt_flag", halted, 1'b1);
      viol = 0;
      repeat (10) begin
         tick();
         if (mem_req !== 1'b0) viol++;
      end
      check("halt_req_low", viol, 0);
      check("halt_retired", retired, 32'd1);
`else
      wait_retired(32'd3, 400, n);
      check("loop_not_halted", halted, 1'b0);
      check("loop_mem16", bswap(mem[4]), 32'd0);
`endif
      cpu_en = 1'b0;
      repeat (8) tick();

      // Random memory image against an instruction-level interpreter.
      max_delay = 2;
      foreach (mem[i]) begin
         mem[i] = $urandom;
         lm[i] = bswap(mem[i]);
      end
      exp_addr_q.delete();
      exp_data_q.delete();
      pc = 32'd0;
      for (int k = 0; k < N_RAND + 2; k++) begin
         if (k == N_RAND) foreach (lm[i]) exp_mem[i] = lm[i];
         a = rd(pc);
         b = rd(pc + 32'd4);
         c = rd(pc + 32'd8);
         r = rd(b) - rd(a);
         lm[b[9:2]] = r;
         exp_addr_q.push_back(b);
         exp_data_q.push_back(r);
         pc = ($signed(r) <= 0) ? c : pc + 32'd12;
      end
      sb_writes = 0;
      sb_on = 1;
      do_reset();
      cpu_en = 1'b1;
      wait_retired(N_RAND, N_RAND * 20 + 50, n);
      cpu_en = 1'b0;
      repeat (8) tick();
      sb_on = 0;
      check("rand_writes", sb_writes, N_RAND);
      check("rand_retired", retired, N_RAND);
      mism = 0;
      foreach (mem[i]) if (bswap(mem[i]) !== exp_mem[i]) mism++;
      check("rand_mem_image", mism, 0);

      // Narrow core: address wrap and signed-overflow branch.
      foreach (smem[i]) smem[i] = '0;
      smem[126] = 16'h0010;
      smem[127] = 16'h0012;
      smem[0]   = 16'h0020;
      smem[8]   = 16'h0001;
      smem[9]   = 16'h8000;
      max_delay = 0;
      do_reset();
      s_en = 1'b1;
      tick();
      check("s_fetch_a", s_addr, 8'd252);
      tick();
      check("s_fetch_b", s_addr, 8'd254);
      tick();
      check("s_fetch_c_wrap", s_addr, 8'd0);
      repeat (3) tick();
      check("s_write_we", s_we, 1'b1);
      check("s_write_data", s_wdata, 16'h7FFF);
      tick();
      check("s_retired", s_retired, 32'd1);
      check("s_next_pc", s_addr, 8'd2);
      s_en = 1'b0;
      tick();
      check("s_mem_result", smem[9], 16'h7FFF);
      check("s_halted", s_halted, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
